// File: rtl/lab5_queue_pkg.sv
// Shared types and constants for the switch-panel FIFO and its display.
// Pure declarations: no logic, no latency, no flow control.
package lab5_pkg;

   localparam int DEF_DATA_W = 6;
   localparam int DEF_DEPTH  = 16;

   // Encoding mirrors sw[7:6] on the front panel
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_DEQ  = 2'b01,
      OP_ENQ  = 2'b10,
      OP_BAD  = 2'b11
   } op_e;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/lab5_queue_if.sv
// Front-panel bundle of the queue: switches, button, two digits and status.
// Wiring only; the panel side is master, the queue is slave.
interface lab5_queue_if
   import lab5_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);
   logic [DATA_W+1:0]       sw;
   logic                    do_op;
   logic [6:0]              seg0;
   logic [6:0]              seg1;
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic                    empty;
   logic                    err;

   modport master (
      output sw, do_op,
      input  seg0, seg1, count, full, empty, err
   );

   modport slave (
      input  sw, do_op,
      output seg0, seg1, count, full, empty, err
   );
endinterface

// File: rtl/lab5_queue_seg7_digit.sv
// One decimal digit to active-low 7-segment pattern; inputs 10..15 blank.
// Purely combinational, no flow control.
module seg7_digit
   import lab5_pkg::*;
(
   input  logic [3:0] bin,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bin)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/lab5_queue.sv
// Button-driven FIFO showing its head in decimal; a press commits SYNC_STAGES edges
// after do_op is first sampled low. No backpressure: overflow/underflow set sticky err.
module lab5_queue
   import lab5_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   lab5_queue_if.slave  qif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   do_sync;
   logic                   do_prev;
   logic                   op_pulse;

   logic [DATA_W-1:0]      mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       cnt;
   logic                   err_q;

   op_e                    op;
   logic                   do_enq;
   logic                   do_deq;
   logic                   set_err;
   logic                   full_w;
   logic                   empty_w;

   logic [DATA_W-1:0]      head;
   logic [3:0]             ones;
   logic [3:0]             tens;

   assign do_sync  = sync_q[SYNC_STAGES-1];
   assign op_pulse = do_prev & ~do_sync;
   assign full_w   = (cnt == CNT_W'(DEPTH));
   assign empty_w  = (cnt == '0);

   // Idle level is 1 so leaving reset with the button up cannot fake a press
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         do_prev <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], qif.do_op};
         do_prev <= do_sync;
      end
   end

   always_comb begin
      op      = op_e'(qif.sw[DATA_W+1:DATA_W]);
      do_enq  = 1'b0;
      do_deq  = 1'b0;
      set_err = 1'b0;
      if (op_pulse) begin
         case (op)
            OP_ENQ: begin
               if (full_w) set_err = 1'b1;
               else        do_enq  = 1'b1;
            end
            OP_DEQ: begin
               if (empty_w) set_err = 1'b1;
               else         do_deq  = 1'b1;
            end
            default: begin
               do_enq = 1'b0;
            end
         endcase
      end
   end

   // Vacated slots are zeroed so stale data never lingers in storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (do_enq) begin
            mem[wr_ptr] <= qif.sw[DATA_W-1:0];
            wr_ptr      <= wr_ptr + PTR_W'(1);
            cnt         <= cnt + CNT_W'(1);
         end
         if (do_deq) begin
            mem[rd_ptr] <= '0;
            rd_ptr      <= rd_ptr + PTR_W'(1);
            cnt         <= cnt - CNT_W'(1);
         end
         if (set_err) err_q <= 1'b1;
      end
   end

   assign head = empty_w ? '0 : mem[rd_ptr];
   assign ones = 4'(head % DATA_W'(10));
   assign tens = 4'(head / DATA_W'(10));

   seg7_digit u_ones (
      .bin (ones),
      .seg (qif.seg0)
   );

   seg7_digit u_tens (
      .bin (tens),
      .seg (qif.seg1)
   );

   assign qif.count = cnt;
   assign qif.full  = full_w;
   assign qif.empty = empty_w;
   assign qif.err   = err_q;

endmodule

// File: tb/tb_lab5_queue.sv
// Directed bench for lab5_queue: a queue-based reference model checked every cycle,
// plus literal expectations at key points of the scenario.
module tb_lab5_queue;

   logic clk;
   logic rst;

   lab5_queue_if qif ();

   lab5_queue dut (
      .clk (clk),
      .rst (rst),
      .qif (qif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // Reference model: a press whose low level is first seen at edge k lands at edge k+2
   int  mq [$];
   bit  merr;
   bit  started = 1'b0;
   bit  s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         merr    = 1'b0;
         s1      = 1'b1;
         s2      = 1'b1;
         s3      = 1'b1;
         started = 1'b1;
      end else begin
         if (started && s3 && !s2) begin
            case (qif.sw[7:6])
               2'b10: if (mq.size() < 16) mq.push_back(int'(qif.sw[5:0])); else merr = 1'b1;
               2'b01: if (mq.size() > 0) void'(mq.pop_front()); else merr = 1'b1;
               default: ;
            endcase
         end
         s3 = s2;
         s2 = s1;
         s1 = qif.do_op;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         int h;
         h = (mq.size() == 0) ? 0 : mq[0];
         chk("count", int'(qif.count), mq.size());
         chk("empty", int'(qif.empty), int'(mq.size() == 0));
         chk("full",  int'(qif.full),  int'(mq.size() == 16));
         chk("err",   int'(qif.err),   int'(merr));
         chk("seg0",  int'(qif.seg0),  int'(segtab[h % 10]));
         chk("seg1",  int'(qif.seg1),  int'(segtab[h / 10]));
      end
   end

   task automatic press(input logic [1:0] op, input int d, input int hold);
      @(posedge clk);
      #2;
      qif.sw    = {op, 6'(d)};
      qif.do_op = 1'b0;
      repeat (hold) @(posedge clk);
      #2 qif.do_op = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      qif.do_op = 1'b1;
      qif.sw    = 8'h00;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("lit_idle_count", int'(qif.count), 0);
      chk("lit_idle_empty", int'(qif.empty), 1);
      chk("lit_idle_err",   int'(qif.err),   0);
      chk("lit_idle_seg1",  int'(qif.seg1),  7'b1000000);
      chk("lit_idle_seg0",  int'(qif.seg0),  7'b1000000);

      // ENQ 42 with cycle-exact latency checks
      @(posedge clk);
      #2;
      qif.sw    = {2'b10, 6'd42};
      qif.do_op = 1'b0;
      @(posedge clk);
      #2 qif.do_op = 1'b1;
      @(negedge clk);
      chk("lit_lat_k0_count", int'(qif.count), 0);
      @(negedge clk);
      chk("lit_lat_k1_count", int'(qif.count), 0);
      @(negedge clk);
      chk("lit_lat_k2_count", int'(qif.count), 1);
      chk("lit_42_seg1", int'(qif.seg1), 7'b0011001);
      chk("lit_42_seg0", int'(qif.seg0), 7'b0100100);
      repeat (3) @(posedge clk);

      press(2'b10, 7, 1);
      @(negedge clk);
      chk("lit_two_count", int'(qif.count), 2);
      chk("lit_two_seg0",  int'(qif.seg0),  7'b0100100);

      press(2'b01, 0, 1);
      @(negedge clk);
      chk("lit_07_seg1",  int'(qif.seg1),  7'b1000000);
      chk("lit_07_seg0",  int'(qif.seg0),  7'b1111000);
      chk("lit_07_count", int'(qif.count), 1);
      press(2'b01, 0, 1);
      @(negedge clk);
      chk("lit_drain_empty", int'(qif.empty), 1);
      press(2'b01, 0, 1);
      @(negedge clk);
      chk("lit_underflow_err",   int'(qif.err),   1);
      chk("lit_underflow_count", int'(qif.count), 0);

      // Fill to capacity, overflow, drain in order
      do_reset();
      for (int i = 0; i < 16; i++) press(2'b10, i, 1);
      @(negedge clk);
      chk("lit_full",     int'(qif.full), 1);
      chk("lit_full_err", int'(qif.err),  0);
      press(2'b10, 63, 1);
      @(negedge clk);
      chk("lit_overflow_err",  int'(qif.err),   1);
      chk("lit_overflow_full", int'(qif.full),  1);
      for (int i = 0; i < 16; i++) press(2'b01, 0, 1);
      @(negedge clk);
      chk("lit_drained_count", int'(qif.count), 0);

      // Pointer wrap: both pointers pass through 15 -> 0
      do_reset();
      for (int i = 0; i < 10; i++) press(2'b10, 50 + i, 1);
      for (int i = 0; i < 10; i++) press(2'b01, 0, 1);
      for (int i = 0; i < 12; i++) press(2'b10, 20 + i, 1);
      @(negedge clk);
      chk("lit_wrap_count", int'(qif.count), 12);
      chk("lit_wrap_seg1",  int'(qif.seg1),  7'b0100100);
      chk("lit_wrap_seg0",  int'(qif.seg0),  7'b1000000);
      for (int i = 0; i < 11; i++) press(2'b01, 0, 1);
      @(negedge clk);
      chk("lit_wrap_last_seg1", int'(qif.seg1), 7'b0110000);
      chk("lit_wrap_last_seg0", int'(qif.seg0), 7'b1111001);
      press(2'b01, 0, 1);

      // Long hold is one press; illegal op code is ignored
      do_reset();
      press(2'b10, 5, 50);
      @(negedge clk);
      chk("lit_hold_count", int'(qif.count), 1);
      press(2'b11, 9, 1);
      @(negedge clk);
      chk("lit_bad_count", int'(qif.count), 1);
      chk("lit_bad_err",   int'(qif.err),   0);

      // Reset arriving on the pulse cycle wins
      @(posedge clk);
      #2;
      qif.sw    = {2'b10, 6'd9};
      qif.do_op = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst       = 1'b1;
      qif.do_op = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("lit_rstpulse_count", int'(qif.count), 0);
      chk("lit_rstpulse_empty", int'(qif.empty), 1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lab5_queue.md
Name: lab5_queue

Overview:
- 16-entry, 6-bit first-in/first-out queue; the read-from-the-far-end counterpart to the lab's switch-driven LIFO stack.
- Same front panel:
  - sw[5:0] carry the data value.
  - sw[7:6] select the operation.
  - Active-low push-button do_op commits the operation.
  - Two 7-segment digits show the element at the head of the queue in decimal.
- Fully synchronous: the button is synchronized and edge-detected on clk, so every operation is a single-cycle event.

Parameters:
- DATA_W, 6: width of each queue element and of sw data field.
- DEPTH, 16: number of entries; power of two; pointers wrap modulo DEPTH.
- SYNC_STAGES, 2: flip-flop stages in the do_op synchronizer.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  8  [5:0] data, [7] enqueue select, [6] dequeue select.
- do_op  input  1  asynchronous active-low push-button; a falling edge commits one operation.
- seg0  output  7  ones digit, active-low segments {g,f,e,d,c,b,a}.
- seg1  output  7  tens digit, same encoding.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- err  output  1  sticky; set on enqueue-when-full or dequeue-when-empty.

Behaviour:
- Reset (rst high at a clk edge):
  - rd_ptr, wr_ptr, count, err and all entries cleared to 0.
  - Synchronizer and edge-detect flops set to 1 (button idle), so releasing reset never yields a spurious operation.
  - Outputs after reset: count=0, empty=1, full=0, err=0, seg0=seg1=7'b1000000 (shows "00").
  - rst has priority over any pending op_pulse; a press whose pulse coincides with rst is discarded.
- Synchronizer and edge detect:
  - do_op passes through SYNC_STAGES flops to give do_sync.
  - One further flop holds do_prev.
  - op_pulse = do_prev & ~do_sync, high for exactly one clk per press regardless of hold time; no debounce beyond this.
- Latency: do_op first sampled low at edge k → op_pulse high in the cycle after edge k+SYNC_STAGES-1 → state updates at edge k+SYNC_STAGES. With defaults, queue contents and outputs change at edge k+2.
- Operation decode (only while op_pulse=1):
  - sw[7:6]=2'b10 ENQ:
    - If !full: mem[wr_ptr] <= sw[5:0], wr_ptr++, count++.
    - Else: no state change except err <= 1.
  - sw[7:6]=2'b01 DEQ:
    - If !empty: mem[rd_ptr] <= 0, rd_ptr++, count--.
    - Else: err <= 1.
  - 2'b00 and 2'b11: no operation; err unchanged.
  - Only one operation per pulse, so there is no simultaneous enqueue/dequeue case.
- Pointer wrap: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally. full/empty derive from count, never from pointer comparison.
- Head value:
  - head = empty ? 0 : mem[rd_ptr], combinational from registers.
  - Display is valid in the same cycle state updates.
  - After enqueue into an empty queue, head equals the written value at edge k+2.
- Display:
  - ones = head % 10, tens = head / 10.
  - 6-bit range 0..63, so tens ≤ 6.
  - Both digits are combinational from head, each through one seg7_digit instance.
- Digit encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10..15 give blank 1111111.
- err clears only on rst.

Decomposition:
- Package lab5_pkg:
  - DATA_W and DEPTH defaults.
  - op_e enum {OP_NONE=2'b00, OP_DEQ=2'b01, OP_ENQ=2'b10, OP_BAD=2'b11}, matching sw[7:6].
  - SEG_* active-low digit constants and SEG_BLANK.
- Sub-module seg7_digit: 4-bit binary in, 7-bit active-low segments out, blank for inputs above 9; instantiated twice.
- Synchronizer, edge detect and queue storage stay in lab5_queue.

Test Plan:
- Reset, then idle 10 cycles with do_op=1 → count=0, empty=1, err=0, seg1/seg0 show "00", no op_pulse.
- ENQ 42, then ENQ 7 → after first press the display shows "42" at edge k+2; after second count=2 and display still "42" (FIFO head unchanged).
- DEQ once → display "07", count=1. DEQ again → empty=1, display "00". Third DEQ → err=1, count stays 0.
- Enqueue 0..15 (16 presses) → full=1. ENQ 63 → err=1, full stays 1. Dequeue all 16, checking head 0,1,…,15 in order.
- Wrap-around: enqueue 10, dequeue 10, enqueue 12 (wr_ptr wraps at 16) → count=12, head equals first of the 12 values. Dequeue all and check order.
- Hold do_op low 50 cycles with sw[7:6]=2'b10 → exactly one enqueue. sw[7:6]=2'b11 press → no change, err unchanged. Assert rst in the same cycle as op_pulse → queue empty, op ignored.
